// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by instr_fetch_unit and anything that decodes its outputs.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetchState_e;

  localparam int INSTR_BYTES = 4;
  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 21;

  // All-zero word: the decoder maps opcode 0 to its inert control set.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and
// presents a held instruction to the decoder; taken branches discard in-flight work.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [10:0]            opCode,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  fetchState_e            state_r;
  fetchState_e            stateNext_s;
  logic [ADDR_WIDTH-1:0]  pc_r;
  logic [ADDR_WIDTH-1:0]  pcNext_s;
  logic [ADDR_WIDTH-1:0]  pendTarget_r;
  logic [ADDR_WIDTH-1:0]  pendTargetNext_s;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [INSTR_WIDTH-1:0] instrNext_s;
  logic [ADDR_WIDTH-1:0]  instrPc_r;
  logic [ADDR_WIDTH-1:0]  instrPcNext_s;
  logic                   instrValid_r;
  logic                   instrValidNext_s;
  logic                   imemReq_r;
  logic                   imemReqNext_s;
  logic [ADDR_WIDTH-1:0]  alignedTarget_s;
  logic [ADDR_WIDTH-1:0]  pcPlus_s;

  assign alignedTarget_s = {branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign pcPlus_s        = pc_r + ADDR_WIDTH'(INSTR_BYTES);

  // Next-state, PC and output-register update for the fetch FSM.
  always_comb begin
    stateNext_s      = state_r;
    pcNext_s         = pc_r;
    pendTargetNext_s = pendTarget_r;
    instrNext_s      = instr_r;
    instrPcNext_s    = instrPc_r;
    instrValidNext_s = instrValid_r;

    case (state_r)
      IDLE: begin
        stateNext_s = WAIT;
        if (branch_taken) begin
          pcNext_s = alignedTarget_s;
        end else begin
          pcNext_s = pc_r;
        end
      end

      WAIT: begin
        if (branch_taken) begin
          if (imem_ack) begin
            pcNext_s    = alignedTarget_s;
            stateNext_s = WAIT;
          end else begin
            // Request still in flight: keep imem_addr stable, redirect after ack.
            pendTargetNext_s = alignedTarget_s;
            stateNext_s      = FLUSH;
          end
        end else if (imem_ack) begin
          instrNext_s      = imem_rdata;
          instrPcNext_s    = pc_r;
          instrValidNext_s = 1'b1;
          pcNext_s         = pcPlus_s;
          stateNext_s      = HOLD;
        end else begin
          stateNext_s = WAIT;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pcNext_s         = alignedTarget_s;
          instrNext_s      = INSTR_WIDTH'(NOP_INSTR);
          instrValidNext_s = 1'b0;
          stateNext_s      = WAIT;
        end else if (!stall) begin
          instrNext_s      = INSTR_WIDTH'(NOP_INSTR);
          instrValidNext_s = 1'b0;
          stateNext_s      = WAIT;
        end else begin
          stateNext_s = HOLD;
        end
      end

      FLUSH: begin
        if (imem_ack) begin
          // A redirect arriving with the ack is newer than the pending one.
          if (branch_taken) begin
            pcNext_s = alignedTarget_s;
          end else begin
            pcNext_s = pendTarget_r;
          end
          stateNext_s = WAIT;
        end else begin
          if (branch_taken) begin
            pendTargetNext_s = alignedTarget_s;
          end else begin
            pendTargetNext_s = pendTarget_r;
          end
          stateNext_s = FLUSH;
        end
      end

      default: begin
        stateNext_s      = IDLE;
        pcNext_s         = RESET_PC;
        instrNext_s      = INSTR_WIDTH'(NOP_INSTR);
        instrValidNext_s = 1'b0;
      end
    endcase

    imemReqNext_s = (stateNext_s == WAIT) || (stateNext_s == FLUSH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      pendTarget_r <= {ADDR_WIDTH{1'b0}};
      instr_r      <= INSTR_WIDTH'(NOP_INSTR);
      instrPc_r    <= {ADDR_WIDTH{1'b0}};
      instrValid_r <= 1'b0;
      imemReq_r    <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      pc_r         <= pcNext_s;
      pendTarget_r <= pendTargetNext_s;
      instr_r      <= instrNext_s;
      instrPc_r    <= instrPcNext_s;
      instrValid_r <= instrValidNext_s;
      imemReq_r    <= imemReqNext_s;
    end
  end

  assign imem_req    = imemReq_r;
  assign imem_addr   = pc_r;
  assign instr_valid = instrValid_r;
  assign instr       = instr_r;
  assign instr_pc    = instrPc_r;
  assign opCode      = instr_r[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-programmable memory model
// pushes accepted words, the decoder side pops and compares them.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [10:0] opCode;
  logic [63:0] instr_pc;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .opCode(opCode), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  int          vecCount = 0;
  int          errCount = 0;
  int          memLat   = 1;
  int          memCnt   = 0;
  logic        justAcked = 1'b0;
  logic        expValid  = 1'b0;
  logic        expReq    = 1'b0;
  logic        flushPend = 1'b0;
  logic [63:0] expAddr   = 64'h0;
  logic [63:0] pendAddr  = 64'h0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecCount++;
    if (got !== want) begin
      errCount++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return 32'h8B02_0020 ^ (a[31:0] * 32'h9E37_79B9);
  endfunction

  // One clock: observe at negedge, run the memory, drive inputs, advance the model.
  task automatic tick(input logic br, input logic [63:0] tgt, input logic st);
    logic        ackNow;
    logic [63:0] t;
    logic [31:0] w;
    sbEntry_t    e;
    @(negedge clk);
    checkVal("valid", {63'h0, instr_valid}, {63'h0, expValid});
    checkVal("req", {63'h0, imem_req}, {63'h0, expReq});
    if (expReq) checkVal("addr", imem_addr, expAddr);
    if (expValid) begin
      if (sbQ.size() == 0) begin
        checkVal("sbEmpty", 64'h0, 64'h1);
      end else begin
        e = sbQ[0];
        w = e.word;
        checkVal("instr", {32'h0, instr}, {32'h0, w});
        checkVal("instrPc", instr_pc, e.pc);
        checkVal("opCode", {53'h0, opCode}, {53'h0, w[31:21]});
        if (br || !st) void'(sbQ.pop_front());
      end
    end else begin
      checkVal("instrZero", {32'h0, instr}, 64'h0);
      checkVal("opZero", {53'h0, opCode}, 64'h0);
    end

    if (justAcked) memCnt = 0;
    ackNow = 1'b0;
    if (imem_req) begin
      memCnt++;
      ackNow = (memCnt >= memLat);
    end else begin
      memCnt = 0;
    end
    imem_ack      = ackNow;
    imem_rdata    = ackNow ? memWord(imem_addr) : $urandom;
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    justAcked     = ackNow;

    t = {tgt[63:2], 2'b00};
    if (expValid) begin
      if (br) begin
        expValid = 1'b0; expReq = 1'b1; expAddr = t;
      end else if (!st) begin
        expValid = 1'b0; expReq = 1'b1;
      end
    end else if (expReq) begin
      if (ackNow) begin
        if (flushPend) begin
          flushPend = 1'b0;
          expAddr   = br ? t : pendAddr;
        end else if (br) begin
          expAddr = t;
        end else begin
          e.pc = expAddr; e.word = memWord(expAddr);
          sbQ.push_back(e);
          expValid = 1'b1; expReq = 1'b0; expAddr = expAddr + 64'd4;
        end
      end else if (br) begin
        flushPend = 1'b1; pendAddr = t;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    branch_taken = 1'b0; branch_target = 64'h0; stall = 1'b0;
    @(negedge clk);
    checkVal("rstReq", {63'h0, imem_req}, 64'h0);
    checkVal("rstValid", {63'h0, instr_valid}, 64'h0);
    checkVal("rstInstr", {32'h0, instr}, 64'h0);
    checkVal("rstOp", {53'h0, opCode}, 64'h0);
    checkVal("rstPc", instr_pc, 64'h0);
    rst = 1'b0;
    // The coming edge leaves IDLE for the first fetch at the reset PC.
    expValid = 1'b0; expReq = 1'b1; expAddr = 64'h0; flushPend = 1'b0;
    sbQ.delete(); memCnt = 0; justAcked = 1'b0;
  endtask

  task automatic waitFresh();
    int n;
    n = 0;
    do begin
      tick(1'b0, 64'h0, 1'b0);
      n++;
    end while (!(memCnt == 1 && !justAcked && !flushPend) && n < 40);
    if (n >= 40) checkVal("waitFreshTO", 64'h0, 64'h1);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    do begin
      tick(1'b0, 64'h0, 1'b0);
      n++;
    end while (!expValid && n < 40);
    if (n >= 40) checkVal("waitValidTO", 64'h0, 64'h1);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    branch_taken = 1'b0; branch_target = 64'h0; stall = 1'b0;

    // First fetch at 0, then stall the second instruction for several cycles.
    memLat = 1;
    doReset();
    repeat (3) tick(1'b0, 64'h0, 1'b0);
    repeat (6) tick(1'b0, 64'h0, 1'b1);
    repeat (3) tick(1'b0, 64'h0, 1'b0);

    // Branch in the second cycle of a slow fetch.
    memLat = 4;
    waitFresh();
    tick(1'b1, 64'h100, 1'b0);
    repeat (8) tick(1'b0, 64'h0, 1'b0);

    // Branch coincident with ack, unaligned target.
    waitFresh();
    repeat (2) tick(1'b0, 64'h0, 1'b0);
    tick(1'b1, 64'h203, 1'b0);
    repeat (10) tick(1'b0, 64'h0, 1'b0);

    // Two redirects while flushing: the last one wins.
    waitFresh();
    tick(1'b1, 64'h40, 1'b0);
    tick(1'b1, 64'h80, 1'b0);
    repeat (10) tick(1'b0, 64'h0, 1'b0);

    // PC wraps past the top of the address space.
    memLat = 1;
    waitValid();
    tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    repeat (6) tick(1'b0, 64'h0, 1'b0);

    // Branch in HOLD under stall, then reset mid-WAIT.
    waitValid();
    memLat = 3;
    tick(1'b1, 64'h300, 1'b1);
    tick(1'b0, 64'h0, 1'b0);
    doReset();
    memLat = 1;
    repeat (4) tick(1'b0, 64'h0, 1'b0);

    // Mixed traffic: random stalls, latencies and redirects.
    repeat (300) begin
      if (memCnt == 0) memLat = $urandom_range(1, 3);
      tick(($urandom_range(0, 9) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    end
    repeat (6) tick(1'b0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
